// File: rtl/seq_add_sub.sv
// Multi-cycle WIDTH-bit adder/subtractor that sums CHUNK bits per clock.
// Results (s, cout, o, z) update only on the one-cycle done pulse.
module seq_add_sub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             o,
  output logic             z
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] r_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             o_q;
  logic             z_q;

  logic [CHUNK-1:0] cx_d;
  logic [CHUNK-1:0] cy_d;
  logic [CHUNK:0]   sum_d;
  logic [WIDTH-1:0] res_d;
  logic             cmsb_d;

  // Current chunk sum; the carry into the top bit is recovered from its sum bit.
  always_comb begin
    cx_d   = x_q[int'(k_q)*CHUNK +: CHUNK];
    cy_d   = y_q[int'(k_q)*CHUNK +: CHUNK];
    sum_d  = {1'b0, cx_d} + {1'b0, cy_d} + {{CHUNK{1'b0}}, c_q};
    res_d  = r_q;
    res_d[int'(k_q)*CHUNK +: CHUNK] = sum_d[CHUNK-1:0];
    cmsb_d = cx_d[CHUNK-1] ^ cy_d[CHUNK-1] ^ sum_d[CHUNK-1];
  end

  // Control FSM plus operand, partial-result and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      o_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            x_q     <= x;
            y_q     <= sub ? ~y : y;
            c_q     <= cin ^ sub;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          r_q <= res_d;
          c_q <= sum_d[CHUNK];
          k_q <= k_q + KW'(1);
          if (k_q == K_LAST) begin
            s_q     <= res_d;
            cout_q  <= sum_d[CHUNK];
            o_q     <= cmsb_d ^ sum_d[CHUNK];
            z_q     <= (res_d == {WIDTH{1'b0}});
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            k_q     <= '0;
            state_q <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign o    = o_q;
  assign z    = z_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Randomized and directed self-checking bench for seq_add_sub (WIDTH=32, CHUNK=8).
module tb_seq_add_sub;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic             clk, rst, start, sub, cin;
  logic [WIDTH-1:0] x, y;
  logic             busy, done, cout, o, z;
  logic [WIDTH-1:0] s;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] cur_s;
  logic             cur_c, cur_o, cur_z;

  seq_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
    .x(x), .y(y), .busy(busy), .done(done), .s(s),
    .cout(cout), .o(o), .z(z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input bit sb, input bit ci, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] es, output logic ec, output logic eo, output logic ez);
    longint ua, ub, sa, sbv, sr;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (sb) begin
      es = a - b - 32'(ci);
      ec = (ua >= ub + longint'(ci));
      sr = sa - sbv - longint'(ci);
    end else begin
      es = a + b + 32'(ci);
      ec = (ua + ub + longint'(ci)) >= 64'sh1_0000_0000;
      sr = sa + sbv + longint'(ci);
    end
    eo = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    ez = (es == 32'd0);
  endtask

  // Called at posedge+1 while idle or in the done cycle; returns in the done cycle.
  task automatic run_op(input bit sb, input bit ci, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [31:0] es;
    logic ec, eo, ez;
    model(sb, ci, a, b, es, ec, eo, ez);
    start = 1'b1; sub = sb; cin = ci; x = a; y = b;
    @(posedge clk); #1;
    start = 1'b0; x = $urandom; y = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    chk("busy_after_start", busy, 1'b1);
    for (int i = 1; i <= N; i++) begin
      @(posedge clk); #1;
      if (i < N) begin
        chk("busy_run", busy, 1'b1);
        chk("done_early", done, 1'b0);
        chk("s_hold", s, cur_s);
        chk("cout_hold", cout, cur_c);
        start = (poke && i == 1);
        x = $urandom; y = $urandom;
      end else begin
        start = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("s", s, es);
        chk("cout", cout, ec);
        chk("o", o, eo);
        chk("z", z, ez);
        cur_s = es; cur_c = ec; cur_o = eo; cur_z = ez;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("done_one_cycle", done, 1'b0);
    chk("busy_idle", busy, 1'b0);
    chk("s_idle_hold", s, cur_s);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s"}, s, 32'd0);
    chk({tag, "_cout"}, cout, 1'b0);
    chk({tag, "_o"}, o, 1'b0);
    chk({tag, "_z"}, z, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  logic [31:0] corner [5];
  logic [31:0] a, b;

  initial begin
    corner[0] = 32'h0000_0000; corner[1] = 32'hFFFF_FFFF; corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h0000_0001;
    cur_s = 32'd0; cur_c = 1'b0; cur_o = 1'b0; cur_z = 1'b0;
    rst = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; x = 32'd0; y = 32'd0;
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk_zero("post_reset");

    run_op(1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0); idle_cycle();
    run_op(1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 1'b0); idle_cycle();
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0); idle_cycle();
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 1'b0); idle_cycle();
    run_op(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0003, 1'b0); idle_cycle();

    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      run_op(1'($urandom), 1'($urandom), a, b, 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

    // Start poked during RUN is ignored; start in the done cycle chains back-to-back.
    run_op(1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    run_op(1'b1, 1'b0, 32'h0000_0100, 32'h0000_0001, 1'b0);
    idle_cycle();

    start = 1'b1; sub = 1'b0; cin = 1'b0; x = 32'hDEAD_BEEF; y = 32'h0000_0001;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1 chk_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    cur_s = 32'd0; cur_c = 1'b0; cur_o = 1'b0; cur_z = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", done, 1'b0);
      chk("no_busy_after_abort", busy, 1'b0);
    end
    run_op(1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
    chk("after_abort_s7", s, 32'd7);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
